// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester round-robin front end for a shared ALU.
// Ports: clk/rst, req0_*/req1_* request channels, ALU drive (OPA..INP_VALID),
//        ALU return (RES + flags), rsp_* one-cycle response with owner id.
module alu_arbiter #(
  parameter int WIDTH     = 8,
  parameter int CMD_WIDTH = 4,
  parameter int MUL_LAT   = 2,
  parameter int STD_LAT   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [WIDTH-1:0]     req0_opa,
  input  logic [WIDTH-1:0]     req0_opb,
  input  logic [CMD_WIDTH:0]   req0_cmd,
  input  logic                 req0_mode,
  input  logic                 req0_cin,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [WIDTH-1:0]     req1_opa,
  input  logic [WIDTH-1:0]     req1_opb,
  input  logic [CMD_WIDTH:0]   req1_cmd,
  input  logic                 req1_mode,
  input  logic                 req1_cin,
  output logic [WIDTH-1:0]     OPA,
  output logic [WIDTH-1:0]     OPB,
  output logic [CMD_WIDTH:0]   CMD,
  output logic                 MODE,
  output logic                 CIN,
  output logic                 CE,
  output logic [1:0]           INP_VALID,
  input  logic [WIDTH:0]       RES,
  input  logic                 OFLOW,
  input  logic                 COUT,
  input  logic                 E,
  input  logic                 G,
  input  logic                 L,
  input  logic                 ERR,
  output logic                 rsp_valid,
  output logic                 rsp_id,
  output logic [WIDTH:0]       rsp_res,
  output logic [5:0]           rsp_flags
);

  localparam int MAXLAT = (MUL_LAT > STD_LAT) ? MUL_LAT : STD_LAT;
  localparam int CW     = (MAXLAT > 2) ? $clog2(MAXLAT) : 1;

  // Counter holds "remaining WAIT cycles minus one", so WAIT lasts LAT cycles.
  localparam logic [CW-1:0] MUL_LD = CW'(MUL_LAT - 1);
  localparam logic [CW-1:0] STD_LD = CW'(STD_LAT - 1);

  localparam logic [CMD_WIDTH:0] CMD_MUL_A = (CMD_WIDTH + 1)'(9);
  localparam logic [CMD_WIDTH:0] CMD_MUL_B = (CMD_WIDTH + 1)'(10);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  state_t               state_q, state_d;
  logic                 ptr_q, ptr_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [WIDTH-1:0]     opa_q, opa_d;
  logic [WIDTH-1:0]     opb_q, opb_d;
  logic [CMD_WIDTH:0]   cmd_q, cmd_d;
  logic                 mode_q, mode_d;
  logic                 cin_q, cin_d;
  logic                 id_q, id_d;
  logic                 rid_q, rid_d;
  logic [WIDTH:0]       rres_q, rres_d;
  logic [5:0]           rfl_q, rfl_d;

  logic gnt0, gnt1, is_mul, idle;

  // Pointer only breaks ties; a lone requester always wins.
  assign gnt0 = req0_valid & (~req1_valid | ~ptr_q);
  assign gnt1 = req1_valid & (~req0_valid | ptr_q);
  assign idle = (state_q == IDLE);

  assign is_mul = mode_q & ((cmd_q == CMD_MUL_A) | (cmd_q == CMD_MUL_B));

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    cmd_d   = cmd_q;
    mode_d  = mode_q;
    cin_d   = cin_q;
    id_d    = id_q;
    rid_d   = rid_q;
    rres_d  = rres_q;
    rfl_d   = rfl_q;
    unique case (state_q)
      IDLE: begin
        if (gnt0 | gnt1) begin
          opa_d   = gnt1 ? req1_opa  : req0_opa;
          opb_d   = gnt1 ? req1_opb  : req0_opb;
          cmd_d   = gnt1 ? req1_cmd  : req0_cmd;
          mode_d  = gnt1 ? req1_mode : req0_mode;
          cin_d   = gnt1 ? req1_cin  : req0_cin;
          id_d    = gnt1;
          ptr_d   = ~gnt1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = is_mul ? MUL_LD : STD_LD;
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == '0) begin
          rres_d  = RES;
          rfl_d   = {OFLOW, COUT, E, G, L, ERR};
          rid_d   = id_q;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      cnt_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      cmd_q   <= '0;
      mode_q  <= 1'b0;
      cin_q   <= 1'b0;
      id_q    <= 1'b0;
      rid_q   <= 1'b0;
      rres_q  <= '0;
      rfl_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      cmd_q   <= cmd_d;
      mode_q  <= mode_d;
      cin_q   <= cin_d;
      id_q    <= id_d;
      rid_q   <= rid_d;
      rres_q  <= rres_d;
      rfl_q   <= rfl_d;
    end
  end

  // Readies are combinational, so reset must mask them directly.
  assign req0_ready = ~rst & idle & gnt0;
  assign req1_ready = ~rst & idle & gnt1;

  assign OPA       = opa_q;
  assign OPB       = opb_q;
  assign CMD       = cmd_q;
  assign MODE      = mode_q;
  assign CIN       = cin_q;
  assign CE        = (state_q == ISSUE) | (state_q == WAIT);
  assign INP_VALID = (state_q == ISSUE) ? 2'b11 : 2'b00;
  assign rsp_valid = (state_q == RESP);
  assign rsp_id    = rid_q;
  assign rsp_res   = rres_q;
  assign rsp_flags = rfl_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed + randomized checks of alu_arbiter
// against a cycle-timeline reference model and a latency-aware ALU model.
module tb_alu_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req0_ready, req0_mode, req0_cin;
  logic       req1_valid, req1_ready, req1_mode, req1_cin;
  logic [7:0] req0_opa, req0_opb, req1_opa, req1_opb;
  logic [4:0] req0_cmd, req1_cmd;
  logic [7:0] OPA, OPB;
  logic [4:0] CMD;
  logic       MODE, CIN, CE;
  logic [1:0] INP_VALID;
  logic [8:0] RES;
  logic       OFLOW, COUT, E, G, L, ERR;
  logic       rsp_valid, rsp_id;
  logic [8:0] rsp_res;
  logic [5:0] rsp_flags;

  always #5 clk = ~clk;

  alu_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_opa(req0_opa), .req0_opb(req0_opb), .req0_cmd(req0_cmd),
    .req0_mode(req0_mode), .req0_cin(req0_cin),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_opa(req1_opa), .req1_opb(req1_opb), .req1_cmd(req1_cmd),
    .req1_mode(req1_mode), .req1_cin(req1_cin),
    .OPA(OPA), .OPB(OPB), .CMD(CMD), .MODE(MODE), .CIN(CIN), .CE(CE),
    .INP_VALID(INP_VALID), .RES(RES),
    .OFLOW(OFLOW), .COUT(COUT), .E(E), .G(G), .L(L), .ERR(ERR),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_res(rsp_res), .rsp_flags(rsp_flags)
  );

  function automatic logic [8:0] f_res(logic [7:0] a, logic [7:0] b,
                                       logic [4:0] c, logic m, logic ci);
    logic [17:0] p;
    if (m && c == 5'd0) return {1'b0, a} + {1'b0, b} + {8'd0, ci};
    if (m && c == 5'd9) begin
      p = ({10'd0, a} + 18'd1) * ({10'd0, b} + 18'd1);
      return p[8:0];
    end
    if (m && c == 5'd10) begin
      p = {9'd0, a, 1'b0} * {10'd0, b};
      return p[8:0];
    end
    return {1'b0, a ^ b} + {4'd0, c};
  endfunction

  function automatic logic [5:0] f_fl(logic [7:0] a, logic [7:0] b);
    logic [7:0] x;
    x = a ^ b;
    return x[5:0];
  endfunction

  function automatic int f_lat(logic [4:0] c, logic m);
    return (m && (c == 5'd9 || c == 5'd10)) ? 2 : 1;
  endfunction

  // ALU model: result only becomes correct after its latency; before that
  // it shows the complement so an early capture is visible.
  int         alu_age, alu_lat;
  logic [8:0] alu_r;
  logic [5:0] alu_f;
  logic       alu_ok;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_age <= 0;
      alu_lat <= 1;
      alu_r   <= '0;
      alu_f   <= '0;
    end else if (CE && INP_VALID == 2'b11) begin
      alu_age <= 1;
      alu_lat <= f_lat(CMD, MODE);
      alu_r   <= f_res(OPA, OPB, CMD, MODE, CIN);
      alu_f   <= f_fl(OPA, OPB);
    end else if (alu_age != 0 && alu_age < 8) begin
      alu_age <= alu_age + 1;
    end
  end

  assign alu_ok = (alu_age != 0) && (alu_age >= alu_lat);
  assign RES = alu_ok ? alu_r : ~alu_r;
  assign {OFLOW, COUT, E, G, L, ERR} = alu_ok ? alu_f : ~alu_f;

  int n_pass = 0;
  int n_chk  = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
  endtask

  // Reference model: timeline relative to the accept cycle.
  bit         busy, ptr, track;
  int         t, lat;
  logic [7:0] p_opa, p_opb;
  logic [4:0] p_cmd;
  logic       p_mode, p_cin, p_id;
  logic [7:0] e_opa, e_opb;
  logic [4:0] e_cmd;
  logic       e_mode, e_cin, e_rid;
  logic [8:0] e_rres;
  logic [5:0] e_rfl;
  logic       gq[$];

  task automatic model_reset();
    busy = 0; ptr = 0; t = 0; lat = 1;
    e_opa = '0; e_opb = '0; e_cmd = '0; e_mode = 0; e_cin = 0;
    e_rid = 0; e_rres = '0; e_rfl = '0;
  endtask

  task automatic tick();
    logic r0, r1, w, any, ce, rv;
    logic [1:0] iv;
    #1;
    r0 = 0; r1 = 0; w = 0; any = 0;
    if (busy) t++;
    if (!busy) begin
      any = req0_valid | req1_valid;
      w   = (req0_valid & req1_valid) ? ptr : req1_valid;
      if (any) begin r0 = ~w; r1 = w; end
    end
    ce = busy && t >= 1 && t <= 1 + lat;
    iv = (busy && t == 1) ? 2'b11 : 2'b00;
    rv = busy && t == 2 + lat;
    if (rv) begin
      e_rid  = p_id;
      e_rres = f_res(p_opa, p_opb, p_cmd, p_mode, p_cin);
      e_rfl  = f_fl(p_opa, p_opb);
    end
    chk("ctl", {58'd0, req0_ready, req1_ready, CE, INP_VALID, rsp_valid},
        {58'd0, r0, r1, ce, iv, rv});
    chk("ops", {41'd0, OPA, OPB, CMD, MODE, CIN},
        {41'd0, e_opa, e_opb, e_cmd, e_mode, e_cin});
    chk("rsp", {48'd0, rsp_id, rsp_res, rsp_flags},
        {48'd0, e_rid, e_rres, e_rfl});
    if (!busy && any) begin
      p_opa  = w ? req1_opa  : req0_opa;
      p_opb  = w ? req1_opb  : req0_opb;
      p_cmd  = w ? req1_cmd  : req0_cmd;
      p_mode = w ? req1_mode : req0_mode;
      p_cin  = w ? req1_cin  : req0_cin;
      p_id   = w;
      e_opa = p_opa; e_opb = p_opb; e_cmd = p_cmd;
      e_mode = p_mode; e_cin = p_cin;
      lat  = f_lat(p_cmd, p_mode);
      ptr  = ~w;
      busy = 1;
      t    = 0;
      if (track) gq.push_back(req1_ready);
    end else if (rv) begin
      busy = 0;
    end
    @(negedge clk);
  endtask

  task automatic rand_req();
    int s0, s1;
    s0 = $urandom_range(0, 3);
    s1 = $urandom_range(0, 3);
    req0_opa  = 8'($urandom); req0_opb = 8'($urandom);
    req1_opa  = 8'($urandom); req1_opb = 8'($urandom);
    req0_cmd  = (s0 == 0) ? 5'd0 : (s0 == 1) ? 5'd9 :
                (s0 == 2) ? 5'd10 : 5'($urandom);
    req1_cmd  = (s1 == 0) ? 5'd0 : (s1 == 1) ? 5'd9 :
                (s1 == 2) ? 5'd10 : 5'($urandom);
    req0_mode = 1'($urandom); req0_cin = 1'($urandom);
    req1_mode = 1'($urandom); req1_cin = 1'($urandom);
  endtask

  task automatic set0(input logic [7:0] a, input logic [7:0] b,
                      input logic [4:0] c, input logic m);
    req0_opa = a; req0_opb = b; req0_cmd = c; req0_mode = m; req0_cin = 0;
  endtask

  task automatic set1(input logic [7:0] a, input logic [7:0] b,
                      input logic [4:0] c, input logic m);
    req1_opa = a; req1_opb = b; req1_cmd = c; req1_mode = m; req1_cin = 0;
  endtask

  task automatic chk_zero(input string tag);
    chk(tag, {req0_ready, req1_ready, CE, INP_VALID, rsp_valid, rsp_id,
              OPA, OPB, CMD, MODE, CIN, rsp_res, rsp_flags}, 64'd0);
  endtask

  initial begin
    track = 0;
    rst = 1;
    set0(8'hAA, 8'h55, 5'd3, 1'b1);
    set1(8'h12, 8'h34, 5'd9, 1'b1);
    req0_valid = 1; req1_valid = 1;
    model_reset();
    @(negedge clk);
    #1 chk_zero("rst_state");
    @(negedge clk);
    req0_valid = 0; req1_valid = 0;
    rst = 0;

    // single ADD on req0
    set0(8'h0F, 8'h01, 5'd0, 1'b1);
    req0_valid = 1;
    tick();
    req0_valid = 0;
    tick(); tick();
    #1;
    chk("add_rv", {63'd0, rsp_valid}, 64'd1);
    chk("add_id", {63'd0, rsp_id}, 64'd0);
    chk("add_res", {55'd0, rsp_res}, 64'h010);
    tick(); tick();

    // multiply on req1
    set1(8'd3, 8'd4, 5'd9, 1'b1);
    req1_valid = 1;
    tick();
    req1_valid = 0;
    tick(); tick(); tick();
    #1;
    chk("mul_rv", {63'd0, rsp_valid}, 64'd1);
    chk("mul_id", {63'd0, rsp_id}, 64'd1);
    chk("mul_res", {55'd0, rsp_res}, 64'h014);
    tick(); tick();

    // flag capture: E and ERR set
    set0(8'h09, 8'h00, 5'd0, 1'b1);
    req0_valid = 1;
    tick();
    req0_valid = 0;
    tick(); tick();
    #1 chk("flags", {58'd0, rsp_flags}, {58'd0, 6'b001001});
    tick(); tick();

    // contention from reset, inputs churn while not accepted
    rst = 1;
    #1 model_reset();
    @(negedge clk);
    rst = 0;
    req0_valid = 1; req1_valid = 1;
    track = 1;
    for (int i = 0; i < 30; i++) begin
      rand_req();
      tick();
    end
    track = 0;
    req0_valid = 0; req1_valid = 0;
    chk("gnt_cnt", {63'd0, gq.size() >= 4}, 64'd1);
    for (int i = 0; i < gq.size(); i++)
      chk("gnt_alt", {63'd0, gq[i]}, {63'd0, 1'(i % 2)});
    for (int i = 0; i < 10 && busy; i++) tick();
    tick();

    // reset during WAIT of a multiply
    set0(8'd7, 8'd5, 5'd10, 1'b1);
    req0_valid = 1;
    tick();
    req0_valid = 0;
    tick();
    set0(8'h21, 8'h43, 5'd0, 1'b1);
    set1(8'h65, 8'h87, 5'd0, 1'b1);
    req0_valid = 1; req1_valid = 1;
    #2 rst = 1;
    #1 chk_zero("rst_wait");
    model_reset();
    @(negedge clk);
    #1 chk_zero("rst_hold");
    @(negedge clk);
    rst = 0;
    #1 chk("rst_ptr", {62'd0, req0_ready, req1_ready}, 64'd2);
    tick();
    req0_valid = 0; req1_valid = 0;
    for (int i = 0; i < 6; i++) tick();

    // randomized traffic
    for (int i = 0; i < 500; i++) begin
      rand_req();
      req0_valid = 1'($urandom_range(0, 1));
      req1_valid = 1'($urandom_range(0, 1));
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
